// File: rtl/mem_pkg.sv
// mem_pkg -- shared types and constants for the memory stage.
//   state_t      : memory-stage FSM states (IDLE, WAIT, DONE)
//   ERR_*        : ErrCode values reported alongside the ErrFlag pulse
//   timerWidth() : bit width needed by the WAIT-cycle counter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  // Wide enough to hold any value up to maxCount; never narrower than 1 bit.
  function automatic int unsigned timerWidth(input int unsigned maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer -- counts the WAIT cycles of one memory access.
//   CLK, RST : clock, synchronous active-high reset
//   Clear    : zero the count (asserted on the edge that enters WAIT)
//   Enable   : one WAIT cycle has elapsed this clock
//   Expired  : the current WAIT cycle is the TIMEOUT_CYCLES-th one, so an
//              access still unacknowledged at this edge is abandoned
module mem_wait_timer
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  localparam int unsigned CNT_W = timerWidth(TIMEOUT_CYCLES);
  // The first WAIT cycle sees count 0, so the N-th WAIT cycle sees N-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || Clear) begin
      count <= '0;
    end else if (Enable && !Expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign Expired = (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline MEM stage with a req/ack data-memory port.
//   CLK, RST                         : clock, synchronous active-high reset
//   InALUOUT, InStoreData            : EX/MEM address and store data
//   InDmemREB, InDmemWEB             : EX/MEM read/write enables (active low)
//   InEXMEMrd, InRegWrite, InValid   : EX/MEM destination, write enable, slot valid
//   DmemAddr, DmemWData, DmemWe      : registered access request fields
//   DmemReq / DmemAck, DmemRData     : request held high until DmemAck (or
//                                      timeout); DmemRData is valid with DmemAck
//   Stall                            : holds EX/MEM and upstream stages
//   MEMWB*                           : MEM/WB pipeline registers
//   ErrFlag, ErrCode                 : one-cycle error pulse and its code
//   DbgState                         : current FSM state, for observation
// Handshake: a request is presented by raising DmemReq with DmemAddr,
// DmemWData and DmemWe stable; the memory completes it by asserting DmemAck
// for one cycle while DmemReq is high. DmemAck is ignored at any other time.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] InALUOUT,
  input  logic [31:0] InStoreData,
  input  logic        InDmemREB,
  input  logic        InDmemWEB,
  input  logic [4:0]  InEXMEMrd,
  input  logic        InRegWrite,
  input  logic        InValid,
  output logic [31:0] DmemAddr,
  output logic [31:0] DmemWData,
  output logic        DmemReq,
  output logic        DmemWe,
  input  logic        DmemAck,
  input  logic [31:0] DmemRData,
  output logic        Stall,
  output logic [31:0] MEMWBData,
  output logic [31:0] MEMWBALUOUT,
  output logic [4:0]  MEMWBrd,
  output logic        MEMWBRegWrite,
  output logic        MEMWBValid,
  output logic        ErrFlag,
  output logic [1:0]  ErrCode,
  output state_t      DbgState
);

  state_t state, nextState;

  logic isMemOp, isIllegal, isAligned, startAccess;
  logic timerClear, timerEnable, timerExpired;

  // Instruction being serviced, captured when the access starts so that
  // retirement does not depend on what EX/MEM holds during DONE.
  logic [31:0] holdALU;
  logic [4:0]  holdRd;
  logic        holdRegWrite, holdValid, holdIsLoad, holdTimedOut;
  logic [31:0] readData;

  assign isMemOp     = InValid && (InDmemREB != InDmemWEB);
  assign isIllegal   = InValid && !InDmemREB && !InDmemWEB;
  assign isAligned   = (InALUOUT[1:0] == 2'b00);
  assign startAccess = isMemOp && isAligned;
  assign DbgState    = state;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .Clear  (timerClear),
    .Enable (timerEnable),
    .Expired(timerExpired)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState   = state;
    Stall       = 1'b0;
    timerClear  = 1'b0;
    timerEnable = 1'b0;
    case (state)
      IDLE: begin
        if (startAccess) begin
          Stall      = !RST;
          timerClear = 1'b1;
          nextState  = WAIT;
        end
      end
      WAIT: begin
        Stall       = 1'b1;
        timerEnable = 1'b1;
        if (DmemAck || timerExpired) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DmemAddr      <= '0;
      DmemWData     <= '0;
      DmemReq       <= 1'b0;
      DmemWe        <= 1'b0;
      MEMWBData     <= '0;
      MEMWBALUOUT   <= '0;
      MEMWBrd       <= '0;
      MEMWBRegWrite <= 1'b0;
      MEMWBValid    <= 1'b0;
      ErrFlag       <= 1'b0;
      ErrCode       <= ERR_NONE;
      holdALU       <= '0;
      holdRd        <= '0;
      holdRegWrite  <= 1'b0;
      holdValid     <= 1'b0;
      holdIsLoad    <= 1'b0;
      holdTimedOut  <= 1'b0;
      readData      <= '0;
    end else begin
      // Nothing retires unless a branch below says so.
      ErrFlag       <= 1'b0;
      ErrCode       <= ERR_NONE;
      MEMWBValid    <= 1'b0;
      MEMWBRegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (startAccess) begin
            DmemAddr     <= InALUOUT;
            DmemWData    <= InStoreData;
            DmemWe       <= ~InDmemWEB;
            DmemReq      <= 1'b1;
            holdALU      <= InALUOUT;
            holdRd       <= InEXMEMrd;
            holdRegWrite <= InRegWrite;
            holdValid    <= InValid;
            holdIsLoad   <= ~InDmemREB;
            holdTimedOut <= 1'b0;
          end else begin
            // Single-cycle retirement: ALU ops, empty slots and rejected ops.
            MEMWBALUOUT <= InALUOUT;
            MEMWBrd     <= InEXMEMrd;
            MEMWBValid  <= InValid;
            MEMWBData   <= '0;
            if (isIllegal) begin
              ErrFlag <= 1'b1;
              ErrCode <= ERR_ILLEGAL;
            end else if (isMemOp) begin
              ErrFlag <= 1'b1;
              ErrCode <= ERR_MISALIGNED;
            end else begin
              MEMWBRegWrite <= InRegWrite;
            end
          end
        end
        WAIT: begin
          // An ack in the timeout cycle still completes the access.
          if (DmemAck) begin
            readData <= DmemRData;
            DmemReq  <= 1'b0;
          end else if (timerExpired) begin
            DmemReq      <= 1'b0;
            holdTimedOut <= 1'b1;
            ErrFlag      <= 1'b1;
            ErrCode      <= ERR_TIMEOUT;
          end
        end
        DONE: begin
          MEMWBALUOUT <= holdALU;
          MEMWBrd     <= holdRd;
          MEMWBValid  <= holdValid;
          if (holdIsLoad && !holdTimedOut) begin
            MEMWBData     <= readData;
            MEMWBRegWrite <= holdRegWrite;
          end else begin
            MEMWBData     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed and randomized checks of mem_stage against a
// behavioural outcome model (stall count, request count, MEM/WB result,
// error code) derived from the stage's rules.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int unsigned T = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] InALUOUT, InStoreData, DmemRData;
  logic        InDmemREB, InDmemWEB, InRegWrite, InValid, DmemAck;
  logic [4:0]  InEXMEMrd;
  logic [31:0] DmemAddr, DmemWData, MEMWBData, MEMWBALUOUT;
  logic        DmemReq, DmemWe, Stall, MEMWBRegWrite, MEMWBValid, ErrFlag;
  logic [4:0]  MEMWBrd;
  logic [1:0]  ErrCode;
  state_t      dbgState;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST),
    .InALUOUT(InALUOUT), .InStoreData(InStoreData),
    .InDmemREB(InDmemREB), .InDmemWEB(InDmemWEB),
    .InEXMEMrd(InEXMEMrd), .InRegWrite(InRegWrite), .InValid(InValid),
    .DmemAddr(DmemAddr), .DmemWData(DmemWData), .DmemReq(DmemReq),
    .DmemWe(DmemWe), .DmemAck(DmemAck), .DmemRData(DmemRData),
    .Stall(Stall), .MEMWBData(MEMWBData), .MEMWBALUOUT(MEMWBALUOUT),
    .MEMWBrd(MEMWBrd), .MEMWBRegWrite(MEMWBRegWrite), .MEMWBValid(MEMWBValid),
    .ErrFlag(ErrFlag), .ErrCode(ErrCode), .DbgState(dbgState)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          stallCycles;
    int          reqCycles;
    logic [31:0] data;
    logic        regWrite;
    logic        valid;
    logic [1:0]  err;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Outcome of one instruction, straight from the stage's rules.
  function automatic exp_t model(input logic [31:0] addr, input logic reb, input logic web,
                                 input logic rw, input logic valid, input int ackDelay,
                                 input logic [31:0] rdata);
    exp_t e;
    bit memOp, illegal, acked, isLoad;
    memOp   = valid && (reb != web);
    illegal = valid && !reb && !web;
    acked   = (ackDelay >= 0) && (ackDelay < int'(T));
    isLoad  = !reb;
    e.stallCycles = 0;
    e.reqCycles   = 0;
    e.data        = 32'h0;
    e.regWrite    = rw;
    e.valid       = valid;
    e.err         = 2'b00;
    if (illegal) begin
      e.err = 2'b10;
      e.regWrite = 1'b0;
    end else if (memOp && addr[1:0] != 2'b00) begin
      e.err = 2'b01;
      e.regWrite = 1'b0;
    end else if (memOp) begin
      e.reqCycles   = acked ? ackDelay + 1 : int'(T);
      e.stallCycles = 1 + e.reqCycles;
      e.err         = acked ? 2'b00 : 2'b11;
      e.data        = (isLoad && acked) ? rdata : 32'h0;
      e.regWrite    = isLoad && acked && rw;
    end
    return e;
  endfunction

  // Present one instruction and play the memory side; ackDelay is the
  // 0-based WAIT cycle in which DmemAck is returned (-1: never).
  task automatic run_op(input string name, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic reb, input logic web, input logic [4:0] rd,
                        input logic rw, input logic valid, input int ackDelay,
                        input logic [31:0] rdata);
    exp_t e;
    int stallN, reqN, errN, cyc;
    logic [1:0] errSeen;
    bit reqBad, midValid, done, last;
    e = model(addr, reb, web, rw, valid, ackDelay, rdata);
    stallN = 0; reqN = 0; errN = 0; cyc = 0; errSeen = 2'b00;
    reqBad = 0; midValid = 0; done = 0;
    @(negedge CLK);
    InALUOUT = addr; InStoreData = sdata; InDmemREB = reb; InDmemWEB = web;
    InEXMEMrd = rd; InRegWrite = rw; InValid = valid;
    while (!done && cyc < 40) begin
      #1;
      last = !Stall;
      if (Stall) stallN++;
      if (DmemReq) begin
        if (DmemAddr !== addr || DmemWData !== sdata || DmemWe !== ~web) reqBad = 1;
        DmemAck   = (ackDelay == reqN);
        DmemRData = (ackDelay == reqN) ? rdata : $urandom();
        reqN++;
      end else begin
        // Stray acks outside a request must have no effect.
        DmemAck   = 1'($urandom_range(0, 1));
        DmemRData = $urandom();
      end
      @(posedge CLK);
      #1;
      if (ErrFlag) begin
        errN++;
        errSeen = ErrCode;
      end
      if (last) done = 1;
      else if (MEMWBValid) midValid = 1;
      cyc++;
      if (!done) @(negedge CLK);
    end
    DmemAck = 1'b0;
    check($sformatf("%s.retired", name), 32'(done), 32'd1);
    check($sformatf("%s.cycles", name), 32'(cyc), 32'(e.stallCycles + 1));
    check($sformatf("%s.stall", name), 32'(stallN), 32'(e.stallCycles));
    check($sformatf("%s.reqCycles", name), 32'(reqN), 32'(e.reqCycles));
    if (e.reqCycles > 0) check($sformatf("%s.reqFields", name), 32'(reqBad), 32'd0);
    check($sformatf("%s.midValid", name), 32'(midValid), 32'd0);
    check($sformatf("%s.errPulses", name), 32'(errN), (e.err != 2'b00) ? 32'd1 : 32'd0);
    check($sformatf("%s.errCode", name), 32'(errSeen), 32'(e.err));
    check($sformatf("%s.data", name), MEMWBData, e.data);
    check($sformatf("%s.aluout", name), MEMWBALUOUT, addr);
    check($sformatf("%s.rd", name), 32'(MEMWBrd), 32'(rd));
    check($sformatf("%s.regWrite", name), 32'(MEMWBRegWrite), 32'(e.regWrite));
    check($sformatf("%s.valid", name), 32'(MEMWBValid), 32'(e.valid));
  endtask

  task automatic check_cleared(input string name);
    check($sformatf("%s.req", name), 32'(DmemReq), 32'd0);
    check($sformatf("%s.we", name), 32'(DmemWe), 32'd0);
    check($sformatf("%s.addr", name), DmemAddr, 32'd0);
    check($sformatf("%s.wdata", name), DmemWData, 32'd0);
    check($sformatf("%s.wbData", name), MEMWBData, 32'd0);
    check($sformatf("%s.wbAlu", name), MEMWBALUOUT, 32'd0);
    check($sformatf("%s.wbRd", name), 32'(MEMWBrd), 32'd0);
    check($sformatf("%s.wbRegWrite", name), 32'(MEMWBRegWrite), 32'd0);
    check($sformatf("%s.wbValid", name), 32'(MEMWBValid), 32'd0);
    check($sformatf("%s.errFlag", name), 32'(ErrFlag), 32'd0);
    check($sformatf("%s.errCode", name), 32'(ErrCode), 32'd0);
    check($sformatf("%s.state", name), 32'(dbgState), 32'(IDLE));
    check($sformatf("%s.stall", name), 32'(Stall), 32'd0);
  endtask

  initial begin
    // Clock/reset: hold reset with an aligned load presented.
    RST = 1'b1; DmemAck = 1'b0; DmemRData = '0;
    InALUOUT = 32'h40; InStoreData = 32'h0; InDmemREB = 1'b0; InDmemWEB = 1'b1;
    InEXMEMrd = 5'd7; InRegWrite = 1'b1; InValid = 1'b1;
    @(posedge CLK); #1;
    check_cleared("reset");
    @(posedge CLK); #1;
    check_cleared("reset2");
    @(negedge CLK);
    RST = 1'b0; InValid = 1'b0;

    // Directed steps.
    run_op("alu",        32'h10,  32'h0,        1'b1, 1'b1, 5'd3,  1'b1, 1'b1, -1, 32'h0);
    run_op("load",       32'h100, 32'h0,        1'b0, 1'b1, 5'd5,  1'b1, 1'b1,  1, 32'hDEADBEEF);
    run_op("store",      32'h204, 32'hCAFEF00D, 1'b1, 1'b0, 5'd6,  1'b1, 1'b1,  0, 32'h0);
    run_op("misaligned", 32'h102, 32'h0,        1'b0, 1'b1, 5'd8,  1'b1, 1'b1,  0, 32'h1234);
    run_op("illegal",    32'h200, 32'h55,       1'b0, 1'b0, 5'd9,  1'b1, 1'b1,  0, 32'h1);
    run_op("timeout",    32'h300, 32'h0,        1'b0, 1'b1, 5'd10, 1'b1, 1'b1, -1, 32'h0);
    run_op("ackAtLimit", 32'h304, 32'h0,        1'b0, 1'b1, 5'd11, 1'b1, 1'b1,  int'(T) - 1, 32'h600DF00D);
    run_op("bubble",     32'h44,  32'h0,        1'b0, 1'b1, 5'd12, 1'b1, 1'b0,  0, 32'h0);

    // Reset in the middle of an access.
    @(negedge CLK);
    InALUOUT = 32'h400; InDmemREB = 1'b0; InDmemWEB = 1'b1; InValid = 1'b1;
    InEXMEMrd = 5'd13; InRegWrite = 1'b1; DmemAck = 1'b0;
    @(posedge CLK); #1;
    check("rstWait.reqRaised", 32'(DmemReq), 32'd1);
    check("rstWait.inWait", 32'(dbgState), 32'(WAIT));
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_cleared("rstWait");
    @(negedge CLK);
    RST = 1'b0; InValid = 1'b0; DmemAck = 1'b1; DmemRData = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("lateAck%0d.req", i), 32'(DmemReq), 32'd0);
      check($sformatf("lateAck%0d.valid", i), 32'(MEMWBValid), 32'd0);
    end
    DmemAck = 1'b0;
    run_op("aluAfterRst", 32'h18, 32'h0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, -1, 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      logic reb, web, v;
      int kind, ad;
      a    = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      kind = int'($urandom_range(0, 7));
      if (kind <= 2)      begin reb = 1'b0; web = 1'b1; end
      else if (kind <= 5) begin reb = 1'b1; web = 1'b0; end
      else if (kind == 6) begin reb = 1'b1; web = 1'b1; end
      else                begin reb = 1'b0; web = 1'b0; end
      v  = ($urandom_range(0, 7) != 0);
      ad = int'($urandom_range(0, 5)) - 1;
      run_op($sformatf("rand%0d", n), a, $urandom(), reb, web, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), v, ad, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
